// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with wrap-bit pointers, sticky error flags and a registered or fall-through read port.
// Read data is 1 cycle after an accepted pop (FWFT=0) or shown at 0 cycles (FWFT=1); a write while full or a read while empty is dropped and flagged.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0) || (AE_THRESH <= 0) ||
      (AE_THRESH >= AF_THRESH) || (AF_THRESH >= DEPTH)) begin : g_bad_params
    $error("sync_fifo_param: illegal DEPTH/threshold combination");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wr_acc, rd_acc;

  // Occupancy falls out of the wrap bits: equal low bits with differing MSB means full.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (wr_en & full)  ovf_d = 1'b1;
    if (rd_en & empty) unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is deliberately left out of reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (rd_acc) dout_d = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout_q <= '0;
      else        dout_q <= dout_d;
    end

    assign data_out = dout_q;
  end

endmodule
